// File: rtl/pwm_duty_detect.sv
// Measures high time, low time and period of one asynchronous PWM input, and flags
// a waveform stuck at 0% or 100% duty once TIMEOUT_CYCLES pass without an edge.
module pwm_duty_detect #(
    parameter int COUNT_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pwm_in,
    output logic [COUNT_WIDTH-1:0] high_time,
    output logic [COUNT_WIDTH-1:0] low_time,
    output logic [COUNT_WIDTH:0]   period,
    output logic                   valid,
    output logic                   stuck,
    output logic                   stuck_level
);
    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        HIGH      = 2'd1,
        LOW       = 2'd2
    } state_e;

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] IDLE_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_dly_q, s_dly_d;
    logic [COUNT_WIDTH-1:0] hi_cnt_q, hi_cnt_d;
    logic [COUNT_WIDTH-1:0] lo_cnt_q, lo_cnt_d;
    logic [COUNT_WIDTH-1:0] idle_cnt_q, idle_cnt_d;
    logic [COUNT_WIDTH-1:0] high_time_q, high_time_d;
    logic [COUNT_WIDTH-1:0] low_time_q, low_time_d;
    logic [COUNT_WIDTH:0]   period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   stuck_q, stuck_d;
    logic                   stuck_level_q, stuck_level_d;

    logic s, rise, fall, timeout;

    assign s       = sync_q[SYNC_STAGES-1];
    assign rise    = s & ~s_dly_q;
    assign fall    = ~s & s_dly_q;
    assign timeout = ~(rise | fall) && (idle_cnt_q == IDLE_LAST);

    always_comb begin
        sync_d        = {sync_q[SYNC_STAGES-2:0], pwm_in};
        s_dly_d       = s;
        state_d       = state_q;
        hi_cnt_d      = hi_cnt_q;
        lo_cnt_d      = lo_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        high_time_d   = high_time_q;
        low_time_d    = low_time_q;
        period_d      = period_q;
        valid_d       = 1'b0;
        stuck_d       = stuck_q;
        stuck_level_d = stuck_level_q;

        // idle counter parks at its last value so stuck stays asserted without wrapping
        if (rise || fall) begin
            idle_cnt_d = '0;
            stuck_d    = 1'b0;
        end else if (idle_cnt_q != IDLE_LAST) begin
            idle_cnt_d = idle_cnt_q + CNT_ONE;
        end

        case (state_q)
            WAIT_RISE: begin
                if (rise) begin
                    hi_cnt_d = CNT_ONE;
                    state_d  = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    lo_cnt_d = CNT_ONE;
                    state_d  = LOW;
                end else if (hi_cnt_q != CNT_MAX) begin
                    hi_cnt_d = hi_cnt_q + CNT_ONE;
                end
            end
            LOW: begin
                if (rise) begin
                    high_time_d = hi_cnt_q;
                    low_time_d  = lo_cnt_q;
                    period_d    = {1'b0, hi_cnt_q} + {1'b0, lo_cnt_q};
                    valid_d     = 1'b1;
                    hi_cnt_d    = CNT_ONE;
                    state_d     = HIGH;
                end else if (lo_cnt_q != CNT_MAX) begin
                    lo_cnt_d = lo_cnt_q + CNT_ONE;
                end
            end
            default: state_d = WAIT_RISE;
        endcase

        // a timeout abandons the partial period; measurement restarts on the next rise
        if (timeout) begin
            stuck_d       = 1'b1;
            stuck_level_d = s;
            state_d       = WAIT_RISE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= WAIT_RISE;
            sync_q        <= '0;
            s_dly_q       <= 1'b0;
            hi_cnt_q      <= '0;
            lo_cnt_q      <= '0;
            idle_cnt_q    <= '0;
            high_time_q   <= '0;
            low_time_q    <= '0;
            period_q      <= '0;
            valid_q       <= 1'b0;
            stuck_q       <= 1'b0;
            stuck_level_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            s_dly_q       <= s_dly_d;
            hi_cnt_q      <= hi_cnt_d;
            lo_cnt_q      <= lo_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            high_time_q   <= high_time_d;
            low_time_q    <= low_time_d;
            period_q      <= period_d;
            valid_q       <= valid_d;
            stuck_q       <= stuck_d;
            stuck_level_q <= stuck_level_d;
        end
    end

    assign high_time   = high_time_q;
    assign low_time    = low_time_q;
    assign period      = period_q;
    assign valid       = valid_q;
    assign stuck       = stuck_q;
    assign stuck_level = stuck_level_q;

endmodule

// File: doc/pwm_duty_detect.md
Name: pwm_duty_detect

Overview:
- Measures the high time, low time and period of one PWM waveform, such as one rgbPWM colour channel or a motor PWM.
- Sits directly downstream of the PWM generator. Its outputs feed a Microblaze MCS GPI so firmware can check the generated duty cycle.
- Also flags a stuck input (0% or 100% duty), which a period measurement cannot capture.

Parameters:
- COUNT_WIDTH, 32: width of the high/low counters and of the high_time/low_time outputs.
- TIMEOUT_CYCLES, 1000000: clk cycles with no edge before the input is declared stuck. Must be < 2**COUNT_WIDTH − 1.
- SYNC_STAGES, 2: number of synchronizer flops on pwm_in. Legal values are 2 or 3.

Ports:
- clk, input, 1: system clock. All logic is on posedge clk.
- reset, input, 1: asynchronous, active-low reset.
- pwm_in, input, 1: PWM waveform, asynchronous to clk.
- high_time, output, COUNT_WIDTH: clk cycles high in the last complete period.
- low_time, output, COUNT_WIDTH: clk cycles low in the last complete period.
- period, output, COUNT_WIDTH+1: high_time + low_time of the last complete period.
- valid, output, 1: one-cycle pulse when high_time, low_time and period update.
- stuck, output, 1: no edge seen for TIMEOUT_CYCLES.
- stuck_level, output, 1: synchronized pwm_in level at the moment stuck was set.

Behaviour:
- Reset:
  - reset low clears immediately, regardless of clk: all outputs, the synchronizer flops, the edge register, internal counters and the idle counter all go to 0.
  - The FSM goes to WAIT_RISE.
  - A reset mid-measurement discards the partial period. Outputs hold 0 until the first full period after release.
- Synchronizer and edge detect:
  - pwm_in passes through SYNC_STAGES flops to give s.
  - s_d is s delayed by one clk.
  - rise = s & ~s_d; fall = ~s & s_d.
  - An input transition is visible as rise/fall SYNC_STAGES+1 clks later. Edges are detected only on clk sampling; no glitch filtering is applied.
- FSM states: WAIT_RISE, HIGH, LOW.
  - WAIT_RISE:
    - Ignores fall.
    - On rise: hi_cnt <= 1, go to HIGH.
    - No outputs are updated.
  - HIGH:
    - Each clk without fall: hi_cnt <= hi_cnt + 1.
    - On fall: lo_cnt <= 1, go to LOW.
  - LOW:
    - Each clk without rise: lo_cnt <= lo_cnt + 1.
    - On rise, in the same clk edge:
      - high_time <= hi_cnt; low_time <= lo_cnt; period <= hi_cnt + lo_cnt (zero-extended add, no overflow); valid <= 1 for one cycle.
      - Then hi_cnt <= 1, go to HIGH.
  - Result: a waveform high for H clks and low for L clks reports high_time=H, low_time=L, period=H+L.
- Timeout:
  - idle_cnt clears to 0 on any rise or fall, otherwise increments.
  - When idle_cnt reaches TIMEOUT_CYCLES−1, on the next clk:
    - stuck <= 1, stuck_level <= s, go to WAIT_RISE.
    - idle_cnt holds and does not wrap.
  - high_time, low_time and period keep their last values.
  - valid does not pulse on timeout.
- Stuck clear: stuck clears on the first rise or fall after it was set. A falling edge clears stuck while the FSM stays in WAIT_RISE.
- Counters: hi_cnt and lo_cnt saturate at all-ones. Saturation is unreachable when the parameter rule on TIMEOUT_CYCLES holds.
- Output registers: all outputs are registered, with no combinational path from pwm_in. Values are stable between valid pulses.

Test Plan:
- Reset while mid-LOW:
  - Drive reset low during LOW, asynchronously between clk edges.
  - Required: all outputs 0 immediately, before the next clk.
  - After release, the first valid appears only after a full rise→fall→rise.
- Nominal rgbPWM channel:
  - Drive pwm_in with MAX_COUNT=2048, clkPWM=clk, duty 512 (high 512 clks, low 1537 clks).
  - Required: on each valid after the first, high_time=512, low_time=1537, period=2049, with exactly one valid per period.
- Short pulse:
  - Drive high 1 clk, low 3 clks, synchronous to clk.
  - Required: high_time=1, low_time=3, period=4.
  - Edge-to-valid latency = SYNC_STAGES+1 clks after the pwm_in rising transition.
- Stuck high:
  - Set TIMEOUT_CYCLES=100, pwm_in held at 1 after a valid period (high 10, low 10).
  - Required: stuck=1 and stuck_level=1 exactly 100 clks after the last detected edge; high_time=10, low_time=10 unchanged; no valid pulse.
- Stuck low then recovery:
  - Set TIMEOUT_CYCLES=100, hold pwm_in at 0 until stuck=1 with stuck_level=0, then resume a high 4 / low 6 square wave.
  - Required: stuck clears on the first detected rise.
  - The first valid reports high_time=4, low_time=6, period=10 (no stale partial counts).
- Duty change mid-stream:
  - Switch the waveform from high 20/low 80 to high 70/low 30 at a period boundary.
  - Required: successive valid outputs report 20/80 then 70/30, with period=100 throughout and no intermediate mixed value.
